// File: rtl/key_debounce.sv
// Four-key push-button debouncer: 2-flop synchronizer feeding one press/release FSM per key.
// Define KEY_LONGPRESS_EN to add a per-key hold counter and one-shot long-press pulse.
module key_debounce #(
    parameter logic [19:0] DB_CNT   = 20'd500_000,
    parameter logic [26:0] LONG_CNT = 27'd100_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

    localparam logic [19:0] DbLast = DB_CNT - 20'd1;

    typedef enum logic [1:0] {
        StIdle,
        StPWait,
        StPressed,
        StRWait
    } state_e;

    if (DB_CNT < 20'd2) begin : g_bad_db_cnt
        $error("DB_CNT must be at least 2");
    end
    if (LONG_CNT < 27'd2) begin : g_bad_long_cnt
        $error("LONG_CNT must be at least 2");
    end

    // Synchronizer idles at 1 so a reset never looks like a press.
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_key
        state_e      r_state;
        logic [19:0] r_cnt;
        logic        r_level;
        logic        r_press;
        logic        r_release;
        logic        w_key;
        logic        w_press_entry;

        assign w_key         = r_sync2[g];
        assign w_press_entry = (r_state == StPWait) && !w_key && (r_cnt == DbLast);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_state   <= StIdle;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    StIdle: begin
                        if (!w_key) begin
                            r_state <= StPWait;
                            r_cnt   <= '0;
                        end
                    end
                    StPWait: begin
                        if (w_key) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else if (w_press_entry) begin
                            r_state <= StPressed;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 20'd1;
                        end
                    end
                    StPressed: begin
                        if (w_key) begin
                            r_state <= StRWait;
                            r_cnt   <= '0;
                        end
                    end
                    StRWait: begin
                        if (!w_key) begin
                            r_state <= StPressed;
                            r_cnt   <= '0;
                        end else if (r_cnt == DbLast) begin
                            r_state   <= StIdle;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 20'd1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;

`ifdef KEY_LONGPRESS_EN
        localparam logic [26:0] LongLast = LONG_CNT - 27'd1;

        logic [26:0] r_hold;
        logic        r_long_done;
        logic        r_long;

        // Hold time spans R_WAIT too, so a short release glitch does not restart it.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_hold      <= '0;
                r_long_done <= 1'b0;
                r_long      <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (w_press_entry) begin
                    r_hold      <= '0;
                    r_long_done <= 1'b0;
                end else if (r_state == StPressed || r_state == StRWait) begin
                    if (r_hold != LongLast) begin
                        r_hold <= r_hold + 27'd1;
                    end else if (!r_long_done) begin
                        r_long      <= 1'b1;
                        r_long_done <= 1'b1;
                    end
                end
            end
        end

        assign key_long[g] = r_long;
`else
        assign key_long[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized bench for key_debounce: a run-length reference model feeds a pulse scoreboard.
module tb_key_debounce;

    localparam int DB = 4;
    localparam int LG = 16;
`ifdef KEY_LONGPRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int n_cmp = 0;
    int n_fail = 0;
    int edge_no = 0;

    // Reference model: a level flips once DB+1 consecutive synchronized samples disagree with it.
    logic [3:0] m_level;
    int         m_run [4];
    int         m_held [4];
    logic [3:0] m_fired;
    logic [3:0] dq [$];
    ev_t        sb [$];
    ev_t        mon_e;

    key_debounce #(
        .DB_CNT   (20'd4),
        .LONG_CNT (27'd16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check4(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b want %b", nm, edge_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        m_fired = '0;
        for (int k = 0; k < 4; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
        dq.delete();
        dq.push_back(4'hF);
        dq.push_back(4'hF);
        // A pulse launched on the edge just before reset never becomes visible.
        while (sb.size() > 0 && sb[sb.size()-1].cyc == edge_no) sb.delete(sb.size() - 1);
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] eff;
        ev_t        e;
        edge_no++;
        if (rstn) begin
            dq.push_back(raw);
            eff   = dq.pop_front();
            e.cyc = edge_no;
            e.p   = '0;
            e.r   = '0;
            e.l   = '0;
            for (int k = 0; k < 4; k++) begin
                if (m_level[k]) begin
                    m_held[k]++;
                    if (LongEn && m_held[k] == LG && !m_fired[k]) begin
                        e.l[k]     = 1'b1;
                        m_fired[k] = 1'b1;
                    end
                end
                if (!eff[k] != m_level[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DB + 1) begin
                    m_run[k] = 0;
                    if (m_level[k]) begin
                        e.r[k] = 1'b1;
                    end else begin
                        e.p[k]     = 1'b1;
                        m_held[k]  = 0;
                        m_fired[k] = 1'b0;
                    end
                    m_level[k] = ~m_level[k];
                end
            end
            if (|{e.p, e.r, e.l}) sb.push_back(e);
        end
    endtask

    task automatic cycle(input logic [3:0] k);
        key_n = k;
        @(posedge clk);
        model_edge(k);
        #1;
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        repeat (n) cycle(k);
    endtask

    task automatic reset_hold(input logic [3:0] k, input int n);
        rstn = 1'b0;
        model_reset();
        #1;
        check4("rst_level", key_level, 4'h0);
        check4("rst_press", key_press, 4'h0);
        check4("rst_release", key_release, 4'h0);
        check4("rst_long", key_long, 4'h0);
        hold(k, n);
        rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        n_cmp++;
        if (key_level !== m_level) begin
            n_fail++;
            $display("FAIL level @edge %0d: got %b want %b", edge_no, key_level, m_level);
        end
        if (sb.size() > 0 && sb[0].cyc == edge_no) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if ({key_press, key_release, key_long} !== {mon_e.p, mon_e.r, mon_e.l}) begin
                n_fail++;
                $display("FAIL pulse @edge %0d: got p=%b r=%b l=%b want p=%b r=%b l=%b",
                         edge_no, key_press, key_release, key_long, mon_e.p, mon_e.r, mon_e.l);
            end
        end else begin
            n_cmp++;
            if ({key_press, key_release, key_long} !== 12'h000) begin
                n_fail++;
                $display("FAIL stray_pulse @edge %0d: got p=%b r=%b l=%b want none",
                         edge_no, key_press, key_release, key_long);
            end
        end
    end

    initial begin
        logic [3:0] rk;
        int         rl;
        model_reset();
        reset_hold(4'hF, 3);
        hold(4'hF, 5);
        // Clean press and release on key 0.
        hold(4'b1110, 10);
        hold(4'hF, 10);
        // Bounce on key 1: never stable long enough.
        hold(4'b1101, 2);
        hold(4'hF, 1);
        hold(4'b1101, 2);
        hold(4'hF, 8);
        // Press, 3-cycle release glitch, real release.
        hold(4'b1110, 10);
        hold(4'hF, 3);
        hold(4'b1110, 10);
        hold(4'hF, 10);
        // Simultaneous press on keys 1 and 3.
        hold(4'b0101, 10);
        hold(4'hF, 10);
        // Reset during P_WAIT, then during PRESSED, with key 0 held throughout.
        hold(4'b1110, 3);
        reset_hold(4'b1110, 2);
        hold(4'b1110, 12);
        reset_hold(4'b1110, 2);
        hold(4'b1110, 12);
        hold(4'hF, 10);
        // Long hold on key 2.
        hold(4'b1011, 40);
        hold(4'hF, 10);
        // Random patterns with random hold lengths, plus one random-time reset.
        for (int s = 0; s < 90; s++) begin
            rk = 4'($urandom);
            rl = int'($urandom_range(1, 9));
            if (s == 45) reset_hold(rk, 2);
            hold(rk, rl);
        end
        hold(4'hF, 12);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missed_events: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
